// File: rtl/pixel_block_encoder_pkg.sv
// Shared types for the pixel block encoder: FSM state encoding and the
// residual bit-width helper used when building the block header.
package pixel_block_encoder_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    HEADER,
    RESID
  } encoder_state_e;

  // Number of bits needed to represent span: 0 for 0, else floor(log2)+1.
  function automatic int unsigned bits_needed(input int unsigned span);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (span[i]) n = 32'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/pixel_block_encoder_channel_minmax.sv
// Running minimum/maximum tracker for one pixel channel; load restarts the
// range at the first pixel of a block, update folds in later pixels.
module channel_minmax #(
  parameter int CH_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            update_i,
  input  logic [CH_W-1:0] value_i,
  output logic [CH_W-1:0] min_o,
  output logic [CH_W-1:0] max_o
);

  logic [CH_W-1:0] min_q, min_d;
  logic [CH_W-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (load_i) begin
      min_d = value_i;
      max_d = value_i;
    end else if (update_i) begin
      if (value_i < min_q) min_d = value_i;
      if (value_i > max_q) max_d = value_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;

endmodule

// File: rtl/pixel_block_encoder.sv
// Block encoder: buffers up to NUM_PIXELS pixels, emits a header of per-channel
// minimums and residual bit widths, then one min-relative residual per pixel.
module pixel_block_encoder
  import pixel_block_encoder_pkg::*;
#(
  parameter int  NUM_PIXELS = 32,
  parameter int  NUM_CH     = 4,
  parameter int  CH_W       = 8,
  localparam int BW         = $clog2(CH_W + 1),
  localparam int CW         = $clog2(NUM_PIXELS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_CH*CH_W-1:0] in_pixel,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_is_header,
  output logic [NUM_CH*CH_W-1:0] out_data,
  output logic [NUM_CH*BW-1:0]   out_bits,
  output logic [CW-1:0]          out_count,
  output logic                   out_last
);

  localparam int PW = NUM_CH * CH_W;
  localparam int AW = $clog2(NUM_PIXELS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_PIXELS - 1);

  encoder_state_e state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  rd_idx_q, rd_idx_d;
  logic [PW-1:0]  pix_buf_q [NUM_PIXELS];

  logic            accept;
  logic            resid_last;
  logic [PW-1:0]   cur_pix;
  logic [CH_W-1:0] ch_min  [NUM_CH];
  logic [CH_W-1:0] ch_max  [NUM_CH];
  logic [CH_W-1:0] ch_span [NUM_CH];

  assign in_ready   = (state_q == ACCUM);
  assign accept     = in_valid && in_ready;
  assign resid_last = (CW'(rd_idx_q) == count_q - CW'(1));
  assign cur_pix    = pix_buf_q[rd_idx_q];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    channel_minmax #(
      .CH_W(CH_W)
    ) u_minmax (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (accept && (count_q == '0)),
      .update_i(accept),
      .value_i (in_pixel[c*CH_W +: CH_W]),
      .min_o   (ch_min[c]),
      .max_o   (ch_max[c])
    );
    assign ch_span[c] = ch_max[c] - ch_min[c];
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_idx_d = rd_idx_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          count_d = count_q + CW'(1);
          if (in_last || (count_q == LAST_CNT)) state_d = HEADER;
        end
      end
      HEADER: begin
        if (out_ready) begin
          state_d  = RESID;
          rd_idx_d = '0;
        end
      end
      RESID: begin
        if (out_ready) begin
          if (resid_last) begin
            state_d  = ACCUM;
            count_d  = '0;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + AW'(1);
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Output fields derive only from registered state, so they hold while stalled.
  always_comb begin
    out_valid     = 1'b0;
    out_is_header = 1'b0;
    out_data      = '0;
    out_bits      = '0;
    out_count     = '0;
    out_last      = 1'b0;
    case (state_q)
      HEADER: begin
        out_valid     = 1'b1;
        out_is_header = 1'b1;
        out_count     = count_q;
        for (int c = 0; c < NUM_CH; c++) begin
          out_data[c*CH_W +: CH_W] = ch_min[c];
          out_bits[c*BW +: BW]     = BW'(bits_needed(32'(ch_span[c])));
        end
      end
      RESID: begin
        out_valid = 1'b1;
        out_last  = resid_last;
        for (int c = 0; c < NUM_CH; c++) begin
          out_data[c*CH_W +: CH_W] = cur_pix[c*CH_W +: CH_W] - ch_min[c];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      count_q  <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pix_buf_q[count_q[AW-1:0]] <= in_pixel;
  end

endmodule

// File: tb/tb_pixel_block_encoder.sv
// Randomised bench for pixel_block_encoder; expectations come from a per-block
// model that scans the queued pixels for channel ranges.
module tb_pixel_block_encoder;

  localparam int NP   = 32;
  localparam int NC   = 4;
  localparam int CHW  = 8;
  localparam int BW   = $clog2(CHW + 1);
  localparam int CNTW = $clog2(NP + 1);
  localparam int PW   = NC * CHW;

  logic            clk;
  logic            rst_n;
  logic            in_valid, in_ready, in_last;
  logic [PW-1:0]   in_pixel;
  logic            out_valid, out_ready, out_is_header, out_last;
  logic [PW-1:0]   out_data;
  logic [NC*BW-1:0] out_bits;
  logic [CNTW-1:0] out_count;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0]    blockQ[$];
  int               expMin[NC];
  int               expBits[NC];
  logic             bHdr[$];
  logic [PW-1:0]    bData[$];
  logic [NC*BW-1:0] bBits[$];
  logic [CNTW-1:0]  bCount[$];
  logic             bLast[$];
  int               unstable;
  int               feedErr;
  bit               timedOut;

  pixel_block_encoder #(
    .NUM_PIXELS(NP),
    .NUM_CH    (NC),
    .CH_W      (CHW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pixel     (in_pixel),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_is_header(out_is_header),
    .out_data     (out_data),
    .out_bits     (out_bits),
    .out_count    (out_count),
    .out_last     (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int chan(input logic [PW-1:0] p, input int c);
    return int'(p[c*CHW +: CHW]);
  endfunction

  // Per-channel min and the bit width of (max - min), straight from the pixel list.
  function automatic void computeModel();
    for (int c = 0; c < NC; c++) begin
      int lo, hi, d, b;
      lo = 1 << CHW;
      hi = -1;
      foreach (blockQ[i]) begin
        int v;
        v = chan(blockQ[i], c);
        if (v < lo) lo = v;
        if (v > hi) hi = v;
      end
      d = hi - lo;
      b = 0;
      while ((1 << b) <= d) b++;
      expMin[c]  = lo;
      expBits[c] = b;
    end
  endfunction

  function automatic logic [PW-1:0] modelMinWord();
    logic [PW-1:0] w;
    w = '0;
    for (int c = 0; c < NC; c++) w[c*CHW +: CHW] = CHW'(expMin[c]);
    return w;
  endfunction

  function automatic logic [NC*BW-1:0] modelBitsWord();
    logic [NC*BW-1:0] w;
    w = '0;
    for (int c = 0; c < NC; c++) w[c*BW +: BW] = BW'(expBits[c]);
    return w;
  endfunction

  function automatic logic [PW-1:0] modelResid(input logic [PW-1:0] p);
    logic [PW-1:0] w;
    w = '0;
    for (int c = 0; c < NC; c++) w[c*CHW +: CHW] = CHW'(chan(p, c) - expMin[c]);
    return w;
  endfunction

  task automatic randomBlock(input int n, input int rLo, input int rHi);
    logic [PW-1:0] p;
    blockQ.delete();
    for (int i = 0; i < n; i++) begin
      p = $urandom;
      p[CHW-1:0] = CHW'($urandom_range(rHi, rLo));
      blockQ.push_back(p);
    end
  endtask

  // Feeds blockQ one pixel per accepted cycle, with occasional idle cycles that
  // wave in_last while in_valid is low; returns on the cycle after the final accept.
  task automatic feedBlock(input bit useLast);
    feedErr = 0;
    for (int i = 0; i < blockQ.size(); i++) begin
      @(negedge clk);
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_pixel = $urandom;
        @(negedge clk);
      end
      if (in_ready !== 1'b1) feedErr++;
      in_valid = 1'b1;
      in_pixel = blockQ[i];
      in_last  = useLast && (i == blockQ.size() - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Records every accepted beat until the last residual, counting any beat whose
  // fields changed while it was stalled.
  task automatic collectBeats(input bit randReady);
    logic             pValid, pReady, pHdr, pLast;
    logic [PW-1:0]    pData;
    logic [NC*BW-1:0] pBits;
    logic [CNTW-1:0]  pCount;
    bHdr.delete(); bData.delete(); bBits.delete(); bCount.delete(); bLast.delete();
    unstable = 0;
    timedOut = 1'b1;
    pValid = 1'b0; pReady = 1'b1; pHdr = 1'b0; pLast = 1'b0;
    pData = '0; pBits = '0; pCount = '0;
    for (int cyc = 0; cyc < 3000 && timedOut; cyc++) begin
      out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pValid && !pReady &&
          (out_valid !== 1'b1 || out_is_header !== pHdr || out_data !== pData ||
           out_bits !== pBits || out_count !== pCount || out_last !== pLast))
        unstable++;
      if (out_valid === 1'b1 && out_ready) begin
        bHdr.push_back(out_is_header);
        bData.push_back(out_data);
        bBits.push_back(out_bits);
        bCount.push_back(out_count);
        bLast.push_back(out_last);
        if (!out_is_header && out_last) timedOut = 1'b0;
      end
      pValid = out_valid; pReady = out_ready; pHdr = out_is_header; pLast = out_last;
      pData = out_data; pBits = out_bits; pCount = out_count;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_is_header !== 1'b0 || out_last !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got valid=%b hdr=%b last=%b, expected 0/0/0",
               out_valid, out_is_header, out_last);
    end
    total++;
    if (out_data !== '0 || out_bits !== '0 || out_count !== '0) begin
      bad++;
      $display("[TB] FAIL reset_fields: got data=%h bits=%h count=%0d, expected zeros",
               out_data, out_bits, out_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release: got in_ready=%b out_valid=%b, expected 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_random_block(input bit randReady, input string name);
    randomBlock(NP, 0, 255);
    computeModel();
    feedBlock(1'b0);
    total++;
    if (feedErr != 0) begin
      bad++;
      $display("[TB] FAIL %s_feed: got %0d stalled pixels, expected 0", name, feedErr);
    end
    total++;
    if (out_valid !== 1'b1 || out_is_header !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_hdr_latency: got valid=%b hdr=%b in_ready=%b, expected 1/1/0",
               name, out_valid, out_is_header, in_ready);
    end
    collectBeats(randReady);
    total++;
    if (timedOut) begin
      bad++;
      $display("[TB] FAIL %s_timeout: got no final beat, expected out_last beat", name);
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("[TB] FAIL %s_stable: got %0d changed stalled beats, expected 0", name, unstable);
    end
    total++;
    if (bHdr.size() != NP + 1) begin
      bad++;
      $display("[TB] FAIL %s_beats: got %0d, expected %0d", name, bHdr.size(), NP + 1);
    end else begin
      total++;
      if (bHdr[0] !== 1'b1 || bLast[0] !== 1'b0 || bCount[0] !== CNTW'(NP)) begin
        bad++;
        $display("[TB] FAIL %s_hdr: got hdr=%b last=%b count=%0d, expected 1/0/%0d",
                 name, bHdr[0], bLast[0], bCount[0], NP);
      end
      total++;
      if (bData[0] !== modelMinWord() || bBits[0] !== modelBitsWord()) begin
        bad++;
        $display("[TB] FAIL %s_hdr_min_bits: got min=%h bits=%h, expected min=%h bits=%h",
                 name, bData[0], bBits[0], modelMinWord(), modelBitsWord());
      end
      for (int i = 0; i < NP; i++) begin
        total++;
        if (bHdr[i+1] !== 1'b0 || bData[i+1] !== modelResid(blockQ[i]) || bBits[i+1] !== '0 ||
            bCount[i+1] !== '0 || bLast[i+1] !== (i == NP - 1)) begin
          bad++;
          $display("[TB] FAIL %s_resid[%0d]: got hdr=%b data=%h bits=%h cnt=%0d last=%b, expected data=%h last=%b",
                   name, i, bHdr[i+1], bData[i+1], bBits[i+1], bCount[i+1], bLast[i+1],
                   modelResid(blockQ[i]), (i == NP - 1));
        end
      end
    end
  endtask

  task automatic test_constant_block();
    blockQ.delete();
    for (int i = 0; i < NP; i++) blockQ.push_back(32'h40404040);
    feedBlock(1'b0);
    collectBeats(1'b0);
    total++;
    if (bHdr.size() != NP + 1) begin
      bad++;
      $display("[TB] FAIL const_beats: got %0d, expected %0d", bHdr.size(), NP + 1);
    end else begin
      total++;
      if (bData[0] !== 32'h40404040 || bBits[0] !== '0 || bCount[0] !== CNTW'(NP)) begin
        bad++;
        $display("[TB] FAIL const_hdr: got min=%h bits=%h count=%0d, expected 40404040/0/%0d",
                 bData[0], bBits[0], bCount[0], NP);
      end
      for (int i = 1; i <= NP; i++) begin
        total++;
        if (bData[i] !== '0) begin
          bad++;
          $display("[TB] FAIL const_resid[%0d]: got %h, expected 0", i - 1, bData[i]);
        end
      end
    end
  endtask

  task automatic test_bit_widths();
    randomBlock(8, 0, 255);
    blockQ[2][CHW-1:0] = 8'h00;
    blockQ[5][CHW-1:0] = 8'hFF;
    computeModel();
    feedBlock(1'b1);
    collectBeats(1'b0);
    total++;
    if (bBits.size() == 0 || bBits[0][BW-1:0] !== BW'(8) || bBits[0] !== modelBitsWord()) begin
      bad++;
      $display("[TB] FAIL bits_full_range: got %h, expected %h (R=8)",
               (bBits.size() > 0) ? bBits[0] : '0, modelBitsWord());
    end
    randomBlock(6, 16, 19);
    blockQ[0][CHW-1:0] = 8'h10;
    blockQ[3][CHW-1:0] = 8'h13;
    computeModel();
    feedBlock(1'b1);
    collectBeats(1'b0);
    total++;
    if (bBits.size() == 0 || bBits[0][BW-1:0] !== BW'(2) || bData[0][CHW-1:0] !== 8'h10 ||
        bBits[0] !== modelBitsWord()) begin
      bad++;
      $display("[TB] FAIL bits_narrow_range: got bits=%h min=%h, expected bits=%h (R=2) minR=10",
               (bBits.size() > 0) ? bBits[0] : '0, (bData.size() > 0) ? bData[0] : '0,
               modelBitsWord());
    end
  endtask

  task automatic test_short_block();
    randomBlock(5, 0, 255);
    computeModel();
    feedBlock(1'b1);
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL short_hdr: got valid=%b in_ready=%b, expected 1/0", out_valid, in_ready);
    end
    collectBeats(1'b0);
    total++;
    if (bHdr.size() != 6 || bCount[0] !== CNTW'(5) || bData[0] !== modelMinWord()) begin
      bad++;
      $display("[TB] FAIL short_hdr_fields: got beats=%0d count=%0d min=%h, expected 6/5/%h",
               bHdr.size(), (bCount.size() > 0) ? bCount[0] : '0,
               (bData.size() > 0) ? bData[0] : '0, modelMinWord());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (bData[i+1] !== modelResid(blockQ[i]) || bLast[i+1] !== (i == 4)) begin
          bad++;
          $display("[TB] FAIL short_resid[%0d]: got data=%h last=%b, expected data=%h last=%b",
                   i, bData[i+1], bLast[i+1], modelResid(blockQ[i]), (i == 4));
        end
      end
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL short_return: got in_ready=%b out_valid=%b, expected 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_single_pixel();
    randomBlock(1, 0, 255);
    feedBlock(1'b1);
    collectBeats(1'b0);
    total++;
    if (bHdr.size() != 2 || bCount[0] !== CNTW'(1) || bBits[0] !== '0 || bData[0] !== blockQ[0] ||
        bData[1] !== '0 || bLast[1] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_pixel: got beats=%0d count=%0d bits=%h min=%h, expected 2/1/0/%h",
               bHdr.size(), (bCount.size() > 0) ? bCount[0] : '0,
               (bBits.size() > 0) ? bBits[0] : '0, (bData.size() > 0) ? bData[0] : '0, blockQ[0]);
    end
  endtask

  task automatic test_reset_mid_block();
    randomBlock(10, 0, 255);
    feedBlock(1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_count !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_assert: got valid=%b count=%0d, expected 0/0", out_valid, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (5) begin
        @(negedge clk);
        if (out_valid !== 1'b0) seen++;
      end
      total++;
      if (seen != 0) begin
        bad++;
        $display("[TB] FAIL midreset_quiet: got %0d valid cycles, expected 0", seen);
      end
    end
    test_random_block(1'b0, "after_reset");
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b0;
    test_reset();
    test_random_block(1'b0, "random");
    test_constant_block();
    test_bit_widths();
    test_short_block();
    test_single_pixel();
    test_random_block(1'b1, "backpressure");
    test_reset_mid_block();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_block_encoder.md
PIXEL_BLOCK_ENCODER -- requirements
Module: pixel_block_encoder

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 32, maximum pixels per block (>=2).
REQ-002 SHALL have parameter NUM_CH, default 4, channels per pixel (R,G,B,A order, channel 0 = R).
REQ-003 SHALL have parameter CH_W, default 8, bits per channel; BW = $clog2(CH_W+1), CW = $clog2(NUM_PIXELS+1).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  in  1  input pixel valid.
REQ-007 SHALL have port in_ready  out  1  encoder accepts pixel.
REQ-008 SHALL have port in_pixel  in  NUM_CH*CH_W  packed pixel, channel c at bits [c*CH_W +: CH_W].
REQ-009 SHALL have port in_last  in  1  marks final pixel of a short block.
REQ-010 SHALL have port out_valid  out  1  output beat valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts beat.
REQ-012 SHALL have port out_is_header  out  1  beat is header.
REQ-013 SHALL have port out_data  out  NUM_CH*CH_W  header: per-channel min; residual: pixel minus min.
REQ-014 SHALL have port out_bits  out  NUM_CH*BW  header only: per-channel residual bit width.
REQ-015 SHALL have port out_count  out  CW  header only: pixels in block.
REQ-016 SHALL have port out_last  out  1  final residual beat of block.

Function
REQ-017 SHALL implement FSM states ACCUM, HEADER, RESID.
REQ-018 ACCUM: in_ready=1; pixel accepted when in_valid&&in_ready; stored in buffer slot count; count increments.
REQ-019 ACCUM: per-channel running min/max updated on each accept; first pixel of block loads min=max=pixel.
REQ-020 ACCUM->HEADER on accept with in_last=1 or count reaching NUM_PIXELS, whichever first.
REQ-021 in_last SHALL be ignored when in_valid=0.
REQ-022 HEADER: out_valid=1, out_is_header=1, out_data=mins, out_count=block pixel count, out_bits[c]=0 if max-min==0 else floor(log2(max-min))+1.
REQ-023 Header SHALL be valid the cycle after the closing pixel is accepted (1-cycle latency).
REQ-024 HEADER->RESID on out_ready; RESID emits one beat per stored pixel in arrival order, out_data[c]=pixel[c]-min[c] (never negative, CH_W bits).
REQ-025 out_last=1 on residual beat index count-1; on its acceptance FSM returns to ACCUM, count cleared.
REQ-026 in_ready SHALL be 0 in HEADER and RESID.
REQ-027 Output beat fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 out_bits, out_count SHALL be 0 on residual beats; out_last 0 on header beat.
REQ-029 Single-pixel block (in_last on first pixel): count=1, all bits 0, one residual of zeros with out_last=1.

Reset
REQ-030 rst_n low SHALL immediately force ACCUM, count=0, out_valid=0, in_ready=1 after release, all outputs 0.
REQ-031 Reset mid-block SHALL discard buffered pixels and partial header; no beat emitted.
REQ-032 Buffer contents need not be reset.

Structure
REQ-033 Shared package types SHALL hold encoder_state_e enum and a bits-needed function (range -> BW).
REQ-034 One sub-module, channel_minmax, SHALL track min/max for one channel; instantiated NUM_CH times via generate.
REQ-035 Pixel buffer SHALL be a NUM_PIXELS-entry register array indexed by write/read counters.

Verification
REQ-036 32 random pixels, out_ready=1 -> header mins match software per-channel min, count=32, then 32 residuals, out_last on 32nd.
REQ-037 All 32 pixels 0x40404040 -> mins 0x40, all bits 0, residuals all 0.
REQ-038 R values 0x00 and 0xFF among pixels -> out_bits[R]=8; R values 0x10..0x13 only -> out_bits[R]=2.
REQ-039 5 pixels, in_last on 5th -> count=5, 5 residual beats, in_ready returns 1 after 5th beat accepted.
REQ-040 out_ready toggled randomly -> every beat held stable until accepted; no beat lost or duplicated.
REQ-041 rst_n pulsed low after 10 pixels -> out_valid stays 0; next 32-pixel block encodes correctly with no stale data.
